stopwatch_tick_ctrl: RTL

//  Upstream control stage for the stopwatch counter chain. Synchronises and edge-detects raw

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/stopwatch_tick_ctrl_if.sv | 31 +++
 rtl/stopwatch_tick_ctrl_debounce.sv | 47 ++++
 rtl/stopwatch_tick_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and divider-width helper for the stopwatch control stage
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    // Width of a counter that must hold 0 .. div-1; never narrower than one bit.
    function automatic int div_width(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/stopwatch_tick_ctrl_if.sv
// rtl/stopwatch_tick_ctrl_if.sv - button inputs and tick/status outputs of the stopwatch control stage
interface stopwatch_tick_ctrl_if;

    logic btn_start_stop;
    logic btn_clear;
    logic tick;
    logic cnt_clr;
    logic running;
    logic paused;

    // Board/bench side: owns the raw buttons, observes tick and status.
    modport master (
        output btn_start_stop,
        output btn_clear,
        input  tick,
        input  cnt_clr,
        input  running,
        input  paused
    );

    // Control stage side.
    modport slave (
        input  btn_start_stop,
        input  btn_clear,
        output tick,
        output cnt_clr,
        output running,
        output paused
    );

endinterface

// File: rtl/stopwatch_tick_ctrl_debounce.sv
// rtl/stopwatch_tick_ctrl_debounce.sv - level debouncer, present only when STOPWATCH_DEBOUNCE_EN is defined
`ifdef STOPWATCH_DEBOUNCE_EN
module btn_debounce #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_i,
    output logic out_o
);

    localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

    logic          level_q;
    logic [CW-1:0] cnt_q;
    logic          level_d;
    logic [CW-1:0] cnt_d;

    // The counter measures how long the input has disagreed with the accepted level;
    // the level flips on the LIMIT-th consecutive disagreeing sample.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (in_i != level_q) begin
            if (cnt_q == CW'(LIMIT - 1)) begin
                level_d = in_i;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Accepted level and stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_o = level_q;

endmodule
`endif

// File: rtl/stopwatch_tick_ctrl.sv
// rtl/stopwatch_tick_ctrl.sv - button sync/edge detect, IDLE/RUN/PAUSE FSM and tick divider; optional STOPWATCH_DEBOUNCE_EN
module stopwatch_tick_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TICK_HZ     = 1,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_MS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    stopwatch_tick_ctrl_if.slave sw
);

    localparam int DIV   = CLK_FREQ_HZ / TICK_HZ;
    localparam int DIV_W = div_width(DIV);

    if (DIV < 2) begin : g_bad_div
        $error("stopwatch_tick_ctrl: CLK_FREQ_HZ/TICK_HZ must be at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("stopwatch_tick_ctrl: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_MS < 0) begin : g_bad_db
        $error("stopwatch_tick_ctrl: DEBOUNCE_MS must be non-negative");
    end

    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] clr_sync_q;
    logic                   ss_lvl;
    logic                   clr_lvl;
    logic                   ss_prev_q;
    logic                   clr_prev_q;
    logic                   ss_p;
    logic                   clr_p;

    state_t                 state_q;
    state_t                 state_d;
    logic [DIV_W-1:0]       div_cnt_q;
    logic [DIV_W-1:0]       div_cnt_d;
    logic                   at_top;
    logic                   tick_q;
    logic                   tick_d;
    logic                   cnt_clr_q;
    logic                   cnt_clr_d;

    // Bring the raw buttons into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_sync_q  <= '0;
            clr_sync_q <= '0;
        end else begin
            ss_sync_q  <= {ss_sync_q[SYNC_STAGES-2:0], sw.btn_start_stop};
            clr_sync_q <= {clr_sync_q[SYNC_STAGES-2:0], sw.btn_clear};
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam longint DB_LIMIT_L = longint'(DEBOUNCE_MS) * longint'(CLK_FREQ_HZ) / 1000;
    localparam int     DB_LIMIT   = (DB_LIMIT_L < 1) ? 1 : int'(DB_LIMIT_L);

    btn_debounce #(.LIMIT(DB_LIMIT)) u_db_ss (
        .clk   (clk),
        .rst_n (rst_n),
        .in_i  (ss_sync_q[SYNC_STAGES-1]),
        .out_o (ss_lvl)
    );

    btn_debounce #(.LIMIT(DB_LIMIT)) u_db_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .in_i  (clr_sync_q[SYNC_STAGES-1]),
        .out_o (clr_lvl)
    );
`else
    assign ss_lvl  = ss_sync_q[SYNC_STAGES-1];
    assign clr_lvl = clr_sync_q[SYNC_STAGES-1];
`endif

    // Previous level for rising-edge detection, so a held button is one press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_prev_q  <= 1'b0;
            clr_prev_q <= 1'b0;
        end else begin
            ss_prev_q  <= ss_lvl;
            clr_prev_q <= clr_lvl;
        end
    end

    assign ss_p  = ss_lvl & ~ss_prev_q;
    assign clr_p = clr_lvl & ~clr_prev_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: clear beats start/stop; start/stop toggles between RUN and PAUSE.
    always_comb begin
        state_d = state_q;
        if (clr_p) begin
            state_d = ST_IDLE;
        end else if (ss_p) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    assign at_top = (div_cnt_q == DIV_W'(DIV - 1));

    // Divider and registered pulses; the divider keeps counting in the cycle a
    // pause press is sampled and simply holds while paused.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clr_p || state_q == ST_IDLE) begin
            div_cnt_d = '0;
        end else if (state_q == ST_RUN) begin
            div_cnt_d = at_top ? '0 : div_cnt_q + DIV_W'(1);
        end
        tick_d    = (state_q == ST_RUN) && at_top && !clr_p;
        cnt_clr_d = clr_p;
    end

    // Divider count and output pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
            cnt_clr_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
            cnt_clr_q <= cnt_clr_d;
        end
    end

    // Outputs: pulses from registers, status decoded from the state register.
    always_comb begin
        sw.tick    = tick_q;
        sw.cnt_clr = cnt_clr_q;
        sw.running = (state_q == ST_RUN);
        sw.paused  = (state_q == ST_PAUSE);
    end

endmodule
